// File: rtl/bram_stream_dma_if.sv
// rtl/bram_stream_dma_if.sv - command, byte-stream and BRAM-port signals of the stream DMA engine
// slave is the engine side; master is the controller/stream/BRAM side.
interface bram_stream_dma_if #(
  parameter int cnt_width = 16
);
  logic                 cmd_start;
  logic                 cmd_dir;
  logic [15:0]          cmd_base;
  logic [cnt_width-1:0] cmd_words;
  logic                 busy;
  logic                 done;
  logic [7:0]           s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [7:0]           m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [15:0]          mem_a;
  logic [31:0]          mem_do;
  logic                 mem_we;
  logic [31:0]          mem_di;

  modport slave (
    input  cmd_start, cmd_dir, cmd_base, cmd_words,
    input  s_data, s_valid, m_ready, mem_di,
    output busy, done, s_ready, m_data, m_valid, mem_a, mem_do, mem_we
  );

  modport master (
    output cmd_start, cmd_dir, cmd_base, cmd_words,
    output s_data, s_valid, m_ready, mem_di,
    input  busy, done, s_ready, m_data, m_valid, mem_a, mem_do, mem_we
  );
endinterface

// File: rtl/bram_stream_dma.sv
// rtl/bram_stream_dma.sv - byte-stream DMA: packs bytes into BRAM words (LOAD) or streams words out as bytes (DUMP)
// One 32-bit register serves as the packing buffer in LOAD and the output shift register in DUMP.
module bram_stream_dma #(
  parameter int cnt_width = 16
) (
  input  logic              clk,
  input  logic              rst,
  bram_stream_dma_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RDREQ, RDWAIT, SEND, DONE} state_t;

  state_t               state, state_nx;
  logic [15:0]          addr;
  logic [cnt_width-1:0] cnt;
  logic [31:0]          word;
  logic [1:0]           lane;
  logic                 last_word;

  assign last_word = (cnt == cnt_width'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.cmd_start) begin
          if (bus.cmd_words == '0) state_nx = DONE;
          else if (bus.cmd_dir)    state_nx = RDREQ;
          else                     state_nx = LOAD;
        end
      end
      LOAD:   if (bus.s_valid && lane == 2'd3) state_nx = WRITE;
      WRITE:  state_nx = last_word ? DONE : LOAD;
      RDREQ:  state_nx = RDWAIT;
      RDWAIT: state_nx = SEND;
      SEND:   if (bus.m_ready && lane == 2'd3) state_nx = last_word ? DONE : RDREQ;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr <= '0;
      cnt  <= '0;
      word <= '0;
      lane <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_start) begin
            addr <= {bus.cmd_base[15:2], 2'b00};
            cnt  <= bus.cmd_words;
            lane <= '0;
          end
        end
        LOAD: begin
          if (bus.s_valid) begin
            word[{lane, 3'b000} +: 8] <= bus.s_data;
            lane <= lane + 2'd1;
          end
        end
        WRITE: begin
          addr <= addr + 16'd4;
          cnt  <= cnt - cnt_width'(1);
        end
        RDWAIT: begin
          word <= bus.mem_di;
          lane <= '0;
        end
        SEND: begin
          // Lane 0 always sits in the low byte, so shifting presents the next byte.
          if (bus.m_ready) begin
            word <= {8'h00, word[31:8]};
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              addr <= addr + 16'd4;
              cnt  <= cnt - cnt_width'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.s_ready = (state == LOAD);
  assign bus.m_valid = (state == SEND);
  assign bus.m_data  = word[7:0];
  assign bus.mem_a   = addr;
  assign bus.mem_do  = word;
  assign bus.mem_we  = (state == WRITE);
endmodule
